// File: rtl/nn_output_fifo.sv
// Result FIFO between the NN core (valid/ready push side) and a Wishbone slave (DATA/STATUS/CTRL).
// Optional macro NN_OUT_FIFO_THRESH_IRQ_EN adds a CTRL threshold register driving the interrupt.
module nn_output_fifo #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid_i,
  input  logic [DATA_W-1:0] res_data_i,
  output logic              res_ready_o,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  output logic              irq_o
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, count_next;
  logic              underflow, full, empty;
  logic              accept, rd_acc, wr_acc;
  logic              push, pop, flush, set_uf, clr_uf;
  logic [1:0]        reg_off;
  logic [DATA_W-1:0] status_word, ctrl_word, rd_word;
  logic              irq_next;
  logic              unused_ok;

  assign full        = (count == (ADDR_W+1)'(DEPTH));
  assign empty       = (count == '0);
  assign res_ready_o = !full;
  assign reg_off     = wbs_adr_i[3:2];

  // The !wbs_ack_o term makes a held strobe complete once every two cycles.
  assign accept = wbs_cyc_i && wbs_stb_i && !wbs_ack_o &&
                  (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign rd_acc = accept && !wbs_we_i;
  assign wr_acc = accept && wbs_we_i;

  assign push   = res_valid_i && !full;
  assign pop    = rd_acc && (reg_off == OFF_DATA) && !empty;
  assign set_uf = rd_acc && (reg_off == OFF_DATA) && empty;
  assign flush  = wr_acc && (reg_off == OFF_CTRL) && wbs_dat_i[0];
  assign clr_uf = wr_acc && (reg_off == OFF_STATUS) && wbs_dat_i[18];

  assign count_next = flush ? '0
                    : count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= res_data_i;
  end

  // Flush overrides a same-cycle push: the word is written but the pointer reset discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      count <= count_next;
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        underflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
        if (clr_uf)      underflow <= 1'b0;
        else if (set_uf) underflow <= 1'b1;
      end
    end
  end

`ifdef NN_OUT_FIFO_THRESH_IRQ_EN
  logic [7:0] threshold;

  always_ff @(posedge clk) begin
    if (rst)                                 threshold <= 8'd0;
    else if (wr_acc && reg_off == OFF_CTRL)  threshold <= wbs_dat_i[15:8];
  end

  always_comb begin
    ctrl_word       = '0;
    ctrl_word[15:8] = threshold;
  end

  assign irq_next = (threshold != 8'd0) && (32'(count_next) >= 32'(threshold));
`else
  assign ctrl_word = '0;
  assign irq_next  = (count_next != '0);
`endif

  always_comb begin
    status_word           = '0;
    status_word[ADDR_W:0] = count;
    status_word[16]       = empty;
    status_word[17]       = full;
    status_word[18]       = underflow;
  end

  always_comb begin
    rd_word = '0;
    case (reg_off)
      OFF_DATA:   rd_word = empty ? '0 : mem[rd_ptr];
      OFF_STATUS: rd_word = status_word;
      OFF_CTRL:   rd_word = ctrl_word;
      default:    rd_word = '0;
    endcase
  end

  // Wishbone response stage: ack and data land one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_o     <= 1'b0;
    end else begin
      wbs_ack_o <= accept;
      irq_o     <= irq_next;
      if (rd_acc) wbs_dat_o <= rd_word;
    end
  end

endmodule
